// File: rtl/pause_pkg.sv
// Shared definitions for the pause / screen-dim controller: FSM states and
// default tick counts for the common system clock rates.
package pause_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    FADE   = 2'd2,
    DIMMED = 2'd3
  } pause_state_t;

  // 10 s idle before fading, then one fade step every 250 ms.
  localparam int DIM_TICKS_12M  = 120_000_000;
  localparam int FADE_TICKS_12M = 3_000_000;
  localparam int DIM_TICKS_48M  = 480_000_000;
  localparam int FADE_TICKS_48M = 12_000_000;

endpackage

// File: rtl/rgb_shift.sv
// Combinational single-channel dimmer: logical right shift by the dim level,
// so zeros fill from the MSB.
module rgb_shift #(
  parameter int RGB_W = 8,
  parameter int LVL_W = 1
) (
  input  logic [RGB_W-1:0] chan_in,
  input  logic [LVL_W-1:0] level,
  output logic [RGB_W-1:0] chan_out
);

  assign chan_out = chan_in >> level;

endmodule

// File: rtl/pause_dim_ctrl.sv
// Merges the user pause toggle with external pause requests and fades the
// picture in steps while the user pause persists; level changes land at vblank.
module pause_dim_ctrl
  import pause_pkg::*;
#(
  parameter int SRC_N      = 2,
  parameter int RGB_W      = 8,
  parameter int TIMER_W    = 32,
  parameter int DIM_TICKS  = DIM_TICKS_12M,
  parameter int FADE_TICKS = FADE_TICKS_12M,
  parameter int DIM_MAX    = 1
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         user_btn,
  input  logic [SRC_N-1:0]             pause_req,
  input  logic                         ce_pix,
  input  logic                         vblank,
  input  logic [3*RGB_W-1:0]           rgb_in,
  output logic                         pause,
  output logic                         user_paused,
  output logic [$clog2(DIM_MAX+1)-1:0] dim_level,
  output logic [3*RGB_W-1:0]           rgb_out
);

  localparam int LVL_W = $clog2(DIM_MAX + 1);

  localparam logic [TIMER_W-1:0] DIM_LAST  = TIMER_W'(DIM_TICKS - 1);
  localparam logic [TIMER_W-1:0] FADE_LAST = TIMER_W'(FADE_TICKS - 1);
  localparam logic [LVL_W-1:0]   TGT_MAX   = LVL_W'(DIM_MAX);
  localparam logic [LVL_W-1:0]   TGT_ONE   = LVL_W'(1);

  if (DIM_MAX < 1 || DIM_MAX > RGB_W - 1) begin : g_bad_dim_max
    $error("pause_dim_ctrl: DIM_MAX must lie in 1..RGB_W-1");
  end

  logic btn_meta_reg;
  logic btn_sync_reg;
  logic btn_prev_reg;
  logic vblank_prev_reg;

  logic user_paused_reg, user_paused_next;
  pause_state_t state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [LVL_W-1:0] target_reg, target_next;
  logic [LVL_W-1:0] dim_level_reg, dim_level_next;
  logic [3*RGB_W-1:0] rgb_out_reg;
  logic [3*RGB_W-1:0] rgb_shifted;

  logic btn_rise;
  logic toggle_on;
  logic toggle_off;
  logic vblank_rise;

  assign btn_rise    = btn_sync_reg & ~btn_prev_reg;
  assign toggle_on   = btn_rise & ~user_paused_reg;
  assign toggle_off  = btn_rise & user_paused_reg;
  assign vblank_rise = vblank & ~vblank_prev_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btn_meta_reg    <= 1'b0;
      btn_sync_reg    <= 1'b0;
      btn_prev_reg    <= 1'b0;
      vblank_prev_reg <= 1'b0;
      user_paused_reg <= 1'b0;
      state_reg       <= RUN;
      timer_reg       <= '0;
      target_reg      <= '0;
      dim_level_reg   <= '0;
      rgb_out_reg     <= '0;
    end else begin
      btn_meta_reg    <= user_btn;
      btn_sync_reg    <= btn_meta_reg;
      btn_prev_reg    <= btn_sync_reg;
      vblank_prev_reg <= vblank;
      user_paused_reg <= user_paused_next;
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      target_reg      <= target_next;
      dim_level_reg   <= dim_level_next;
      if (ce_pix) begin
        rgb_out_reg <= rgb_shifted;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    target_next      = target_reg;
    user_paused_next = user_paused_reg;
    dim_level_next   = dim_level_reg;

    if (vblank_rise) begin
      dim_level_next = target_reg;
    end

    case (state_reg)
      RUN: begin
        timer_next  = '0;
        target_next = '0;
      end
      WAIT: begin
        if (timer_reg == DIM_LAST) begin
          target_next = TGT_ONE;
          timer_next  = '0;
          state_next  = FADE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      FADE: begin
        if (target_reg == TGT_MAX) begin
          state_next = DIMMED;
          timer_next = '0;
        end else if (timer_reg == FADE_LAST) begin
          target_next = target_reg + 1'b1;
          timer_next  = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      DIMMED: begin
        timer_next = '0;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    if (toggle_on) begin
      user_paused_next = 1'b1;
      state_next       = WAIT;
      timer_next       = '0;
      target_next      = '0;
    end

    // Un-pausing wins over a coincident fade step and restores the picture
    // immediately rather than waiting for the next blank.
    if (toggle_off) begin
      user_paused_next = 1'b0;
      state_next       = RUN;
      timer_next       = '0;
      target_next      = '0;
      dim_level_next   = '0;
    end
  end

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_chan
    rgb_shift #(
      .RGB_W (RGB_W),
      .LVL_W (LVL_W)
    ) u_shift (
      .chan_in  (rgb_in[gi*RGB_W +: RGB_W]),
      .level    (dim_level_reg),
      .chan_out (rgb_shifted[gi*RGB_W +: RGB_W])
    );
  end

  assign pause       = user_paused_reg | (|pause_req);
  assign user_paused = user_paused_reg;
  assign dim_level   = dim_level_reg;
  assign rgb_out     = rgb_out_reg;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Scoreboard bench for pause_dim_ctrl: a cycle model built from elapsed-time
// arithmetic predicts outputs, a negedge monitor compares them.
module tb_pause_dim_ctrl;

  localparam int SRC_N = 2;
  localparam int RGB_W = 8;
  localparam int D     = 10;
  localparam int F     = 4;
  localparam int DMAX  = 3;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              user_btn = 1'b0;
  logic [SRC_N-1:0]  pause_req = '0;
  logic              ce_pix = 1'b0;
  logic              vblank = 1'b0;
  logic [3*RGB_W-1:0] rgb_in = '0;
  logic              pause;
  logic              user_paused;
  logic [1:0]        dim_level;
  logic [3*RGB_W-1:0] rgb_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  pause_dim_ctrl #(
    .SRC_N      (SRC_N),
    .RGB_W      (RGB_W),
    .TIMER_W    (32),
    .DIM_TICKS  (D),
    .FADE_TICKS (F),
    .DIM_MAX    (DMAX)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .user_btn    (user_btn),
    .pause_req   (pause_req),
    .ce_pix      (ce_pix),
    .vblank      (vblank),
    .rgb_in      (rgb_in),
    .pause       (pause),
    .user_paused (user_paused),
    .dim_level   (dim_level),
    .rgb_out     (rgb_out)
  );

  typedef struct {
    logic        pause;
    logic        up;
    logic [1:0]  dim;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: edges since reset, pause start edge, visible level.
  int          m_edge;
  int          m_start;
  bit          m_paused;
  int          m_dim;
  logic [23:0] m_rgb;
  bit          m_btn_prev;
  bit          m_vb_prev;
  int          tog_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int target_now();
    int n;
    int t;
    if (!m_paused) return 0;
    n = m_edge - m_start;
    if (n < D) return 0;
    t = 1 + (n - D) / F;
    return (t > DMAX) ? DMAX : t;
  endfunction

  function automatic logic [23:0] dimmed(input logic [23:0] px, input int lvl);
    logic [23:0] res;
    int ch;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      ch = int'(px[c*8 +: 8]);
      ch = ch / (1 << lvl);
      res[c*8 +: 8] = 8'(ch);
    end
    return res;
  endfunction

  task automatic model_reset();
    m_edge     = 0;
    m_start    = 0;
    m_paused   = 1'b0;
    m_dim      = 0;
    m_rgb      = '0;
    m_btn_prev = 1'b0;
    m_vb_prev  = 1'b0;
    tog_q.delete();
    exp_q.delete();
  endtask

  // Inputs are already set; predict the current window, then advance one edge.
  task automatic cycle();
    exp_t e;
    int   tcur;
    int   new_dim;
    bit   tog;
    e.pause = m_paused | (|pause_req);
    e.up    = m_paused;
    e.dim   = 2'(m_dim);
    e.rgb   = m_rgb;
    exp_q.push_back(e);

    tcur = target_now();
    if (user_btn && !m_btn_prev) tog_q.push_back(m_edge + 3);
    m_btn_prev = user_btn;
    tog = (tog_q.size() > 0) && (tog_q[0] == m_edge + 1);
    if (tog) void'(tog_q.pop_front());
    new_dim = m_dim;
    if (vblank && !m_vb_prev) new_dim = tcur;
    if (tog && m_paused) new_dim = 0;
    if (ce_pix) m_rgb = dimmed(rgb_in, m_dim);
    m_vb_prev = vblank;
    if (tog) begin
      m_paused = !m_paused;
      m_start  = m_edge + 1;
    end
    m_dim = new_dim;
    m_edge++;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic press();
    user_btn = 1'b1;
    repeat (4) cycle();
    user_btn = 1'b0;
    repeat (4) cycle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pause", 32'(pause), 32'(e.pause));
        check("user_paused", 32'(user_paused), 32'(e.up));
        check("dim_level", 32'(dim_level), 32'(e.dim));
        check("rgb_out", 32'(rgb_out), 32'(e.rgb));
      end
    end
  end

  initial begin : driver
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_rgb_out", 32'(rgb_out), 32'h0);
    check("reset_user_paused", 32'(user_paused), 32'h0);
    check("reset_dim_level", 32'(dim_level), 32'h0);
    check("reset_pause", 32'(pause), 32'h0);
    reset = 1'b0;

    // Button latency: paused exactly on the third edge after the raw rise.
    ce_pix = 1'b1;
    rgb_in = 24'h33_66_99;
    user_btn = 1'b1;
    cycle();
    cycle();
    check("btn_latency_early", 32'(user_paused), 32'h0);
    cycle();
    check("btn_latency_up", 32'(user_paused), 32'h1);
    check("btn_latency_pause", 32'(pause), 32'h1);
    cycle();
    user_btn = 1'b0;
    repeat (4) cycle();
    press();
    check("unpause_up", 32'(user_paused), 32'h0);
    check("unpause_dim", 32'(dim_level), 32'h0);

    // Full fade with vblank every 5 cycles.
    rgb_in = 24'hFF_80_01;
    press();
    for (int i = 0; i < 40; i++) begin
      vblank = (i % 5 == 0);
      cycle();
    end
    vblank = 1'b0;
    check("fade_dim_level_max", 32'(dim_level), 32'h3);
    check("fade_rgb_level3", 32'(rgb_out), 32'h1F_10_00);
    press();

    // External request only: pauses the core but never dims.
    pause_req = 2'b10;
    for (int i = 0; i < 50; i++) begin
      vblank = (i % 5 == 0);
      cycle();
    end
    pause_req = '0;
    vblank = 1'b0;
    cycle();

    // Toggle-off lands on the same edge as the 2->3 step.
    press();
    while (m_edge < m_start + D + 2*F - 3) begin
      vblank = (m_edge % 5 == 0);
      cycle();
    end
    user_btn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vblank = (m_edge % 5 == 0);
      cycle();
    end
    user_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vblank = (m_edge % 5 == 0);
      cycle();
    end
    vblank = 1'b0;
    check("collide_up", 32'(user_paused), 32'h0);
    check("collide_dim", 32'(dim_level), 32'h0);

    // Asynchronous reset mid-FADE with the pixel enable idle.
    rgb_in = 24'hFF_80_01;
    press();
    while (m_edge < m_start + D + F + 2) begin
      vblank = (m_edge % 5 == 0);
      cycle();
    end
    vblank = 1'b0;
    ce_pix = 1'b0;
    cycle();
    cycle();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rgb", 32'(rgb_out), 32'h0);
    check("async_rst_up", 32'(user_paused), 32'h0);
    check("async_rst_dim", 32'(dim_level), 32'h0);
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_reset();

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) user_btn = ~user_btn;
      if ($urandom_range(0, 7) == 0) pause_req = SRC_N'($urandom);
      ce_pix = ($urandom_range(0, 2) != 0);
      vblank = ($urandom_range(0, 3) == 0);
      rgb_in = 24'($urandom);
      cycle();
    end
    user_btn = 1'b0;
    pause_req = '0;
    cycle();
    @(negedge clk_sys);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
